// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, total-length helpers and colour-bar palette.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 11;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Bars run left to right; any index past the last bar falls back to black.
  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0:       return COL_WHITE;
      1:       return COL_YELLOW;
      2:       return COL_CYAN;
      3:       return COL_GREEN;
      4:       return COL_MAGENTA;
      5:       return COL_RED;
      6:       return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-region and sync-region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CW         = DEF_CW,
  parameter int TOTAL      = 800,
  parameter int ACTIVE     = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cnt_en,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          active,
  output logic          in_sync
);

  localparam logic [CW-1:0] LAST_CNT   = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_CNT = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_LO    = CW'(SYNC_START);
  localparam logic [CW-1:0] SYNC_HI    = CW'(SYNC_END);

  logic at_last;

  assign at_last = (count == LAST_CNT);
  assign wrap    = cnt_en && at_last;
  assign active  = (count < ACTIVE_CNT);
  assign in_sync = (count >= SYNC_LO) && (count <= SYNC_HI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (cnt_en) begin
      count <= at_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator; define VGA_TIMING_PATTERN_EN to add the o_pattern colour-bar output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CW       = DEF_CW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_active,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_frame_start,
  output logic          o_line_start
`ifdef VGA_TIMING_PATTERN_EN
  ,
  output logic [23:0]   o_pattern
`endif
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          h_act;
  logic          h_sync;
  logic          v_act;
  logic          v_sync;
  logic          frame_wrap_unused;
  logic          line_zero;
  logic          visible;

  vga_axis_counter #(
    .CW        (CW),
    .TOTAL     (H_TOTAL),
    .ACTIVE    (H_ACTIVE),
    .SYNC_START(H_ACTIVE + H_FP),
    .SYNC_END  (H_ACTIVE + H_FP + H_SYNC - 1)
  ) u_h_axis (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .cnt_en (i_enable),
    .count  (h_cnt),
    .wrap   (h_wrap),
    .active (h_act),
    .in_sync(h_sync)
  );

  // The vertical axis steps once per completed line, so vsync edges land on h_cnt=0.
  vga_axis_counter #(
    .CW        (CW),
    .TOTAL     (V_TOTAL),
    .ACTIVE    (V_ACTIVE),
    .SYNC_START(V_ACTIVE + V_FP),
    .SYNC_END  (V_ACTIVE + V_FP + V_SYNC - 1)
  ) u_v_axis (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .cnt_en (h_wrap),
    .count  (v_cnt),
    .wrap   (frame_wrap_unused),
    .active (v_act),
    .in_sync(v_sync)
  );

  assign line_zero = (h_cnt == '0);
  assign visible   = h_act && v_act;

  // Outputs register the decode of the current counts; holding them while disabled freezes pulses too.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_active      <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
    end else if (i_enable) begin
      o_hsync       <= h_sync ? SYNC_POL : ~SYNC_POL;
      o_vsync       <= v_sync ? SYNC_POL : ~SYNC_POL;
      o_active      <= visible;
      o_x           <= h_cnt;
      o_y           <= v_cnt;
      o_frame_start <= line_zero && (v_cnt == '0);
      o_line_start  <= line_zero;
    end
  end

`ifdef VGA_TIMING_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [CW-1:0] bar_sel;

  assign bar_sel = h_cnt / CW'(BAR_W);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_pattern <= 24'h000000;
    end else if (i_enable) begin
      o_pattern <= visible ? bar_colour(int'(bar_sel)) : 24'h000000;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a default 640x480 instance plus a shrunken-timing instance for whole-frame checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic        ls;
    logic [10:0] x;
    logic [10:0] y;
    logic [23:0] pat;
  } obs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  obs_t q_def[$];
  obs_t q_sm[$];
  obs_t def_last;
  obs_t sm_last;
  int   def_mx = 0;
  int   def_my = 0;
  int   sm_mx  = 0;
  int   sm_my  = 0;

  logic        d_hs, d_vs, d_act, d_fs, d_ls;
  logic [10:0] d_x, d_y;
  logic [23:0] d_pat_obs;
  logic        s_hs, s_vs, s_act, s_fs, s_ls;
  logic [10:0] s_x, s_y;
  logic [23:0] s_pat_obs;

  always #5 clk = ~clk;

`ifdef VGA_TIMING_PATTERN_EN
  logic [23:0] d_pat, s_pat;
  assign d_pat_obs = d_pat;
  assign s_pat_obs = s_pat;
`else
  assign d_pat_obs = 24'h000000;
  assign s_pat_obs = 24'h000000;
`endif

  vga_timing_gen dut_def (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .o_hsync      (d_hs),
    .o_vsync      (d_vs),
    .o_active     (d_act),
    .o_x          (d_x),
    .o_y          (d_y),
    .o_frame_start(d_fs),
    .o_line_start (d_ls)
`ifdef VGA_TIMING_PATTERN_EN
    ,
    .o_pattern    (d_pat)
`endif
  );

  // Small raster: 24 clocks per line (hsync 18..20), 15 lines per frame (vsync 10..11).
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0), .CW(11)
  ) dut_sm (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_enable     (en),
    .o_hsync      (s_hs),
    .o_vsync      (s_vs),
    .o_active     (s_act),
    .o_x          (s_x),
    .o_y          (s_y),
    .o_frame_start(s_fs),
    .o_line_start (s_ls)
`ifdef VGA_TIMING_PATTERN_EN
    ,
    .o_pattern    (s_pat)
`endif
  );

  function automatic logic [23:0] colour(input int bar);
    case (bar)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic obs_t resetObs();
    obs_t o;
    o     = '0;
    o.hs  = 1'b1;
    o.vs  = 1'b1;
    return o;
  endfunction

  // Expected registered outputs for raster position (x,y); syncs are active-low.
  function automatic obs_t decode(input int x, input int y, input int ha, input int hsb, input int hse,
                                  input int va, input int vsb, input int vse);
    obs_t o;
    o.act = (x < ha) && (y < va);
    o.hs  = !((x >= hsb) && (x <= hse));
    o.vs  = !((y >= vsb) && (y <= vse));
    o.fs  = (x == 0) && (y == 0);
    o.ls  = (x == 0);
    o.x   = 11'(x);
    o.y   = 11'(y);
`ifdef VGA_TIMING_PATTERN_EN
    o.pat = o.act ? colour(x / (ha / 8)) : 24'h000000;
`else
    o.pat = 24'h000000;
`endif
    return o;
  endfunction

  function automatic void advance(inout int x, inout int y, input int ht, input int vt);
    x = x + 1;
    if (x == ht) begin
      x = 0;
      y = (y + 1 == vt) ? 0 : y + 1;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drives one clock of stimulus and queues what each DUT must show after that edge.
  task automatic applyStimulus(input logic r, input logic e);
    obs_t de, se;
    @(negedge clk);
    rst_n = r;
    en    = e;
    if (!r) begin
      de = resetObs();
      se = resetObs();
      def_mx = 0; def_my = 0;
      sm_mx  = 0; sm_my  = 0;
    end else if (e) begin
      de = decode(def_mx, def_my, 640, 656, 751, 480, 490, 491);
      se = decode(sm_mx, sm_my, 16, 18, 20, 8, 10, 11);
      advance(def_mx, def_my, 800, 525);
      advance(sm_mx, sm_my, 24, 15);
    end else begin
      de = def_last;
      se = sm_last;
    end
    def_last = de;
    sm_last  = se;
    q_def.push_back(de);
    q_sm.push_back(se);
    @(posedge clk);
    #2;
  endtask

  always begin : monitor
    obs_t e;
    @(posedge clk);
    #1;
    if (q_def.size() > 0) begin
      e = q_def.pop_front();
      checkOutput("sb_def", 64'({d_hs, d_vs, d_act, d_fs, d_ls, d_x, d_y, d_pat_obs}), 64'(e));
    end
    if (q_sm.size() > 0) begin
      e = q_sm.pop_front();
      checkOutput("sb_sm", 64'({s_hs, s_vs, s_act, s_fs, s_ls, s_x, s_y, s_pat_obs}), 64'(e));
    end
  end

  initial begin
    int act_cnt, hs_cnt, hs_first, ls_cnt, vs_cnt, vs_x, vs_y, fs_cnt, guard;

    repeat (5) applyStimulus(1'b0, 1'b1);
    checkOutput("rst_def_x", 64'(d_x), 64'(0));
    checkOutput("rst_def_act", 64'(d_act), 64'(0));
    checkOutput("rst_def_hs", 64'(d_hs), 64'(1));

    // First enabled edge after reset shows pixel (0,0).
    applyStimulus(1'b1, 1'b1);
    checkOutput("first_x", 64'(d_x), 64'(0));
    checkOutput("first_y", 64'(d_y), 64'(0));
    checkOutput("first_act", 64'(d_act), 64'(1));
    checkOutput("first_fs", 64'(d_fs), 64'(1));
    checkOutput("first_ls", 64'(d_ls), 64'(1));
    checkOutput("first_hs", 64'(d_hs), 64'(1));
    checkOutput("first_vs", 64'(d_vs), 64'(1));
    checkOutput("first_sm_fs", 64'(s_fs), 64'(1));

    act_cnt = 0; hs_cnt = 0; hs_first = -1; ls_cnt = 0;
    for (int c = 0; c < 800; c++) begin
      if (c > 0) applyStimulus(1'b1, 1'b1);
      if (d_act) act_cnt++;
      if (!d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(d_x);
      end
      if (c > 0 && d_ls) ls_cnt++;
`ifdef VGA_TIMING_PATTERN_EN
      if (d_x == 11'd0)   checkOutput("pat_x0", 64'(d_pat), 64'(24'hFFFFFF));
      if (d_x == 11'd80)  checkOutput("pat_x80", 64'(d_pat), 64'(24'hFFFF00));
      if (d_x == 11'd639) checkOutput("pat_x639", 64'(d_pat), 64'(24'h000000));
      if (d_x == 11'd640) checkOutput("pat_x640", 64'(d_pat), 64'(24'h000000));
`endif
    end
    checkOutput("line_active_cnt", 64'(act_cnt), 64'(640));
    checkOutput("line_hsync_cnt", 64'(hs_cnt), 64'(96));
    checkOutput("line_hsync_first_x", 64'(hs_first), 64'(656));
    checkOutput("line_ls_inside", 64'(ls_cnt), 64'(0));
    applyStimulus(1'b1, 1'b1);
    checkOutput("line2_ls", 64'(d_ls), 64'(1));
    checkOutput("line2_y", 64'(d_y), 64'(1));
    checkOutput("line2_fs", 64'(d_fs), 64'(0));

    // Whole frame on the small raster: 24*15 = 360 clocks.
    repeat (2) applyStimulus(1'b0, 1'b1);
    vs_cnt = 0; vs_x = -1; vs_y = -1; fs_cnt = 0; act_cnt = 0;
    for (int c = 0; c < 360; c++) begin
      applyStimulus(1'b1, 1'b1);
      if (!s_vs) begin
        if (vs_cnt == 0) begin
          vs_x = int'(s_x);
          vs_y = int'(s_y);
        end
        vs_cnt++;
      end
      if (s_fs) fs_cnt++;
      if (s_act) act_cnt++;
    end
    checkOutput("frame_vsync_cnt", 64'(vs_cnt), 64'(48));
    checkOutput("frame_vsync_y", 64'(vs_y), 64'(10));
    checkOutput("frame_vsync_x", 64'(vs_x), 64'(0));
    checkOutput("frame_fs_cnt", 64'(fs_cnt), 64'(1));
    checkOutput("frame_active_cnt", 64'(act_cnt), 64'(128));
    applyStimulus(1'b1, 1'b1);
    checkOutput("frame2_fs", 64'(s_fs), 64'(1));

    // A line-start pulse stays high while disabled.
    guard = 0;
    while (!s_ls && guard < 30) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    checkOutput("wait_sm_ls_timeout", 64'(guard >= 30), 64'(0));
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("hold_sm_ls", 64'(s_ls), 64'(1));
    checkOutput("hold_sm_x", 64'(s_x), 64'(0));

    // Freeze the default raster at (100,50).
    applyStimulus(1'b0, 1'b1);
    guard = 0;
    while (!(d_x == 11'd100 && d_y == 11'd50) && guard < 45000) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    checkOutput("wait_def_100_50_timeout", 64'(guard >= 45000), 64'(0));
    repeat (10) applyStimulus(1'b1, 1'b0);
    checkOutput("freeze_x", 64'(d_x), 64'(100));
    checkOutput("freeze_y", 64'(d_y), 64'(50));
    checkOutput("freeze_act", 64'(d_act), 64'(1));
    applyStimulus(1'b1, 1'b1);
    checkOutput("resume_x", 64'(d_x), 64'(101));
    checkOutput("resume_y", 64'(d_y), 64'(50));

    // Mid-frame reset on the small raster while hsync is asserted (x=20, y=6).
    guard = 0;
    while (!(s_x == 11'd20 && s_y == 11'd6) && guard < 400) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    checkOutput("wait_sm_20_6_timeout", 64'(guard >= 400), 64'(0));
    checkOutput("pre_rst_sm_hs", 64'(s_hs), 64'(0));
    applyStimulus(1'b0, 1'b1);
    checkOutput("midrst_x", 64'(s_x), 64'(0));
    checkOutput("midrst_y", 64'(s_y), 64'(0));
    checkOutput("midrst_hs", 64'(s_hs), 64'(1));
    checkOutput("midrst_ls", 64'(s_ls), 64'(0));
    applyStimulus(1'b1, 1'b1);
    checkOutput("restart_fs", 64'(s_fs), 64'(1));
    checkOutput("restart_act", 64'(s_act), 64'(1));
    applyStimulus(1'b1, 1'b1);
    checkOutput("restart_x1", 64'(s_x), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing (hsync, vsync, active-video enable and pixel coordinates) from the pixel clock.
- Sits directly upstream of the pixel gating mux: o_active drives that mux's i_control, so pixel data is blanked outside the visible area.
- Downstream pixel sources use o_x and o_y to select the pixel for each position.
- Default timing is 640x480 at 60 Hz with a 25.175 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in clocks
- H_SYNC, 96, horizontal sync width in clocks
- H_BP, 48, horizontal back porch in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, sync asserted level (0 = active-low, as for 640x480)
- CW, 11, width of the counters and coordinates; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- i_clk  input  1  pixel clock
- i_rst_n  input  1  synchronous active-low reset
- i_enable  input  1  counters advance only when high
- o_hsync  output  1  horizontal sync, level set by SYNC_POL
- o_vsync  output  1  vertical sync, level set by SYNC_POL
- o_active  output  1  high inside the visible area; feeds the pixel mux control input
- o_x  output  CW  current horizontal count, range 0..H_TOTAL-1
- o_y  output  CW  current vertical count, range 0..V_TOTAL-1
- o_frame_start  output  1  one-cycle pulse at pixel (0,0)
- o_line_start  output  1  one-cycle pulse at x=0 on every line

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Counters: internal h_cnt and v_cnt.
  - When i_enable=1, h_cnt increments each clock and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only on an h_cnt wrap, and wraps from V_TOTAL-1 to 0. Simultaneous wrap of both counters starts a new frame.
- Outputs: all outputs are registered, decoded from the current h_cnt/v_cnt, so they lag the counters by 1 clock. All outputs are mutually aligned within the same cycle.
  - o_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - o_hsync asserted (= SYNC_POL) while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; 656..751 by default. Deasserted (= ~SYNC_POL) otherwise.
  - o_vsync asserted while v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; 490..491 by default. It spans whole lines, switching on the h_cnt=0 boundary.
  - o_x = h_cnt and o_y = v_cnt, unmasked; consumers qualify them with o_active.
  - o_line_start = (h_cnt==0); o_frame_start = (h_cnt==0 && v_cnt==0).
- Reset (synchronous, i_rst_n=0 at a clock edge):
  - h_cnt=0, v_cnt=0.
  - o_hsync=o_vsync=~SYNC_POL, o_active=0, o_x=0, o_y=0, o_frame_start=0, o_line_start=0.
- After reset: on the first clock edge with i_rst_n=1 and i_enable=1, the outputs show (0,0) with o_active=1, o_frame_start=1 and o_line_start=1.
- Reset mid-frame: takes effect at the next edge regardless of position. No partial-line completion.
- i_enable=0: counters and all outputs hold their current values, including any pulse output that is currently high. Resuming continues from the held position.
- Pixel gating: the pixel source must present data for (o_x,o_y) in the same cycle. o_data to the monitor is valid exactly when o_active=1.

Optional Feature:
- Macro: VGA_TIMING_PATTERN_EN.
- Defined:
  - Adds output o_pattern [23:0], registered and aligned with o_active.
  - It shows 8 vertical colour bars, each H_ACTIVE/8 wide, in this order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - o_pattern is 000000 when o_active=0 and at reset.
- Undefined: the port and its logic are absent.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants for 640x480@60;
  - derived H_TOTAL/V_TOTAL functions;
  - the colour-bar constants.
- One sub-module, vga_axis_counter, is natural.
  - Parameters: TOTAL, SYNC_START, SYNC_END, ACTIVE.
  - Inputs/outputs: count-enable in; count, wrap, active and sync out.
  - It is instantiated twice: for H the enable is i_enable; for V the enable is the H wrap.

Test Plan:
- Reset held 5 clocks, then released with i_enable=1 -> first output cycle: o_x=0, o_y=0, o_active=1, o_frame_start=1, o_hsync=1, o_vsync=1.
- Run 800 clocks -> o_active high for exactly 640 cycles; o_hsync low for exactly 96 cycles starting at o_x=656; o_line_start pulses at cycle 800; o_y=1.
- Run a full frame of 420000 clocks -> o_vsync low for exactly 1600 clocks starting at o_y=490, o_x=0; o_frame_start pulses once per 420000 clocks; o_active count = 307200.
- Deassert i_enable for 10 clocks at o_x=100, o_y=50 -> all outputs frozen at (100,50); resume continues at o_x=101.
- Assert reset at o_x=700, o_y=300 -> next edge outputs are at reset values; after release, the sequence restarts at (0,0).
- With VGA_TIMING_PATTERN_EN defined -> o_pattern=FFFFFF at x=0, FFFF00 at x=80, 000000 at x=639, and 000000 at x=640 (blanked).
